// File: rtl/spi_slave.sv
// SPI mode 0 slave with synchronized pin inputs, a one-word transmit holding register
// and a received-word output that pulses rx_valid per complete word.
module spi_slave #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   reload;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q[0] <= sclk;
            cs_sync_q[0]   <= cs_n;
            mosi_sync_q[0] <= mosi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        reload      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!cs_s) begin
                    state_d    = StActive;
                    reload     = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end
            StActive: begin
                if (cs_s) begin
                    state_d    = StIdle;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (bit_cnt_q == CntW'(DATA_WIDTH)) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CntW'(1);
                end else if (sclk_fall) begin
                    // A falling edge with a wrapped counter follows a finished word
                    if (bit_cnt_q == '0) begin
                        reload = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (reload) begin
            hold_full_d = 1'b0;
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        // A write only lands when the register was empty, so a same-cycle reload underruns
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign miso_oe     = (state_q == StActive) && !cs_s;
    assign miso        = miso_oe & tx_shift_q[DATA_WIDTH-1];
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master at clk/16 plus a word-level model of the
// holding register and expected rx/miso streams.
module tb_spi_slave;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         sclk, cs_n, mosi;
    logic         miso, miso_oe;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid, tx_underrun;

    spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: holding register contents, and streams expected vs observed
    logic [W-1:0] hold_model[$];
    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    logic [W-1:0] exp_miso[$];
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] rx_got[$];
    logic [W-1:0] last_rx = '0;
    int           exp_underrun = 0;
    int           underruns = 0;

    always @(negedge clk) begin
        if (rx_valid) rx_got.push_back(rx_data);
        if (tx_underrun) underruns++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        for (int k = 0; k < 400 && !tx_ready; k++) @(negedge clk);
        chk("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        hold_model.push_back(d);
    endtask

    // Master: nbits of mosi drawn from m_tx; ends with sclk high, then cs_n rises
    task automatic spi_frame(input int nbits, input bit finish_frame);
        logic [W-1:0] word, got, cur_exp;
        word    = '0;
        got     = '0;
        cur_exp = '0;
        cs_n    = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i % W == 0) begin
                word = (m_tx.size() > 0) ? m_tx.pop_front() : '0;
                if (hold_model.size() > 0) begin
                    cur_exp = hold_model.pop_front();
                end else begin
                    cur_exp = '0;
                    exp_underrun++;
                end
            end
            mosi = word[W-1-(i%W)];
            half();
            sclk = 1'b1;
            got  = {got[W-2:0], miso};
            if (i % W == W - 1) begin
                m_rx.push_back(got);
                exp_miso.push_back(cur_exp);
                exp_rx.push_back(word);
                last_rx = word;
            end
            half();
            if (i != nbits - 1) sclk = 1'b0;
        end
        if (finish_frame) begin
            cs_n = 1'b1;
            half();
            sclk = 1'b0;
            mosi = 1'b0;
            half();
        end
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_miso_words"}, 32'(m_rx.size()), 32'(exp_miso.size()));
        while (m_rx.size() > 0 && exp_miso.size() > 0)
            chk({tag, "_miso"}, 32'(m_rx.pop_front()), 32'(exp_miso.pop_front()));
        chk({tag, "_rx_words"}, 32'(rx_got.size()), 32'(exp_rx.size()));
        while (rx_got.size() > 0 && exp_rx.size() > 0)
            chk({tag, "_rx"}, 32'(rx_got.pop_front()), 32'(exp_rx.pop_front()));
        chk({tag, "_underruns"}, 32'(underruns), 32'(exp_underrun));
        m_rx.delete();
        exp_miso.delete();
        rx_got.delete();
        exp_rx.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single word
        tx_write(8'hA5);
        m_tx.push_back(8'h3C);
        spi_frame(8, 1'b1);
        check_frame("single");
        chk("single_rx_data", 32'(rx_data), 32'h3C);
        chk("single_tx_ready", 32'(tx_ready), 32'd1);

        // Back-to-back words, second tx written once the first reload frees the register
        tx_write(8'h11);
        m_tx.push_back(8'hF0);
        m_tx.push_back(8'h0F);
        fork
            spi_frame(16, 1'b1);
            tx_write(8'h22);
        join
        check_frame("b2b");

        // Underrun
        m_tx.push_back(8'($urandom));
        spi_frame(8, 1'b1);
        check_frame("underrun");
        chk("underrun_tx_ready", 32'(tx_ready), 32'd1);

        // Abort after 5 bits, then a clean frame
        m_tx.push_back(8'($urandom));
        spi_frame(5, 1'b1);
        chk("abort_miso_oe", 32'(miso_oe), 32'd0);
        chk("abort_miso", 32'(miso), 32'd0);
        chk("abort_rx_data", 32'(rx_data), 32'(last_rx));
        check_frame("abort");
        tx_write(8'h69);
        m_tx.push_back(8'h96);
        spi_frame(8, 1'b1);
        check_frame("after_abort");

        // Reset mid-frame after 3 bits
        tx_write(8'h77);
        m_tx.push_back(8'hFF);
        spi_frame(3, 1'b0);
        reset = 1'b1;
        hold_model.delete();
        last_rx = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_frame("midreset");
        m_tx.push_back(8'h5A);
        spi_frame(8, 1'b1);
        check_frame("post_reset");
        chk("post_reset_rx_data", 32'(rx_data), 32'h5A);

        // Write lands on the same clock as the frame-start reload
        m_tx.push_back(8'($urandom));
        m_tx.push_back(8'($urandom));
        fork
            spi_frame(16, 1'b1);
            begin
                wait (cs_n == 1'b0);
                repeat (SYNC) @(posedge clk);
                @(negedge clk);
                tx_data  = 8'hC3;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                hold_model.push_back(8'hC3);
            end
        join
        check_frame("same_cycle");

        // Random frames
        for (int f = 0; f < 4; f++) begin
            int nw;
            nw = int'($urandom_range(1, 2));
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            for (int w = 0; w < nw; w++) m_tx.push_back(8'($urandom));
            spi_frame(nw * W, 1'b1);
            check_frame("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the bits per SPI word.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, setting the flip-flop depth of the input synchronizers.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-006 cs_n  input  1  active-low chip select from the master, asynchronous to clk.
REQ-007 mosi  input  1  master-out serial data.
REQ-008 miso  output  1  slave-out serial data, MSB first.
REQ-009 miso_oe  output  1  miso drive enable; high only while a frame is active.
REQ-010 tx_data  input  DATA_WIDTH  next word to transmit.
REQ-011 tx_valid  input  1  tx_data is valid.
REQ-012 tx_ready  output  1  the holding register is empty and can accept tx_data.
REQ-013 rx_data  output  DATA_WIDTH  last complete word received.
REQ-014 rx_valid  output  1  one-clk pulse marking a new rx_data.
REQ-015 tx_underrun  output  1  one-clk pulse when a word is started with the holding register empty.

Function
REQ-016 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0): it samples mosi on sclk rising edges and updates miso on sclk falling edges.
REQ-017 The block SHALL pass sclk, cs_n and mosi through SYNC_STAGES flip-flops before any use.
REQ-018 The block SHALL detect sclk edges by comparing the last synchronizer stage with one extra registered copy.
REQ-019 The supported operating range SHALL be sclk at or below clk/8, with each sclk high and low phase at least 4 clk periods.
REQ-020 The block SHALL use a two-state FSM, IDLE and ACTIVE.
REQ-021 IDLE SHALL transition to ACTIVE when the synchronized cs_n falls.
REQ-022 ACTIVE SHALL transition to IDLE when the synchronized cs_n rises.
REQ-023 On the IDLE->ACTIVE transition, the block SHALL load the tx shift register from the holding register, clear the bit counter, and present the shift-register MSB on miso in that same cycle.
REQ-024 On each synchronized sclk rising edge in ACTIVE, the block SHALL shift mosi into the LSB of the rx shift register and increment the bit counter.
REQ-025 On each synchronized sclk falling edge in ACTIVE, the block SHALL shift the tx register left and drive the new MSB on miso, except after the last bit of a word.
REQ-026 When the bit counter reaches DATA_WIDTH on a rising edge, the block SHALL, in the next cycle, copy the full word to rx_data, pulse rx_valid for exactly 1 clk, and wrap the counter to 0.
REQ-027 Latency from an sclk rising edge at the pin to rx_valid SHALL be at most SYNC_STAGES+2 clk.
REQ-028 On the falling edge that follows the last bit of a word (continuous frame), the block SHALL reload the tx shift register from the holding register and drive its MSB.
REQ-029 Multiple back-to-back words within one cs_n assertion SHALL be supported with no gap.
REQ-030 The holding register handshake: tx_ready SHALL equal "holding register empty"; a write SHALL occur when tx_valid and tx_ready are both high, after which the register is full.
REQ-031 A reload from the holding register SHALL empty it.
REQ-032 Underrun: a reload with the holding register empty SHALL load all-zeros and pulse tx_underrun for 1 clk.
REQ-033 A holding-register write in the same cycle as a reload SHALL NOT feed that reload (the reload sees empty, so it underruns), and the written word SHALL remain held for the next reload.
REQ-034 Unless reset, rx_data SHALL hold its value until the next complete word.
REQ-035 A cs_n rise mid-word SHALL discard the partial rx bits with no rx_valid, clear the bit counter, leave the holding register unchanged, and drive miso_oe low in the same cycle.
REQ-036 sclk edges while in IDLE SHALL be ignored.
REQ-037 miso SHALL be 0 whenever miso_oe is low.

Reset
REQ-038 While reset is high, the FSM SHALL be in IDLE.
REQ-039 While reset is high, miso, miso_oe, rx_valid and tx_underrun SHALL all be 0.
REQ-040 While reset is high, rx_data, both shift registers and the bit counter SHALL be 0.
REQ-041 While reset is high, the holding register SHALL be empty, so tx_ready is 1.
REQ-042 While reset is high, all synchronizer stages SHALL be loaded with their idle values (sclk=0, cs_n=1, mosi=0).
REQ-043 Reset asserted mid-frame SHALL abort the frame immediately, with no rx_valid pulse.

Verification
REQ-044 Single word: tx 0xA5 preloaded; master sends 0x3C at clk/16 -> master receives 0xA5; rx_data=0x3C; one rx_valid pulse; no tx_underrun.
REQ-045 Back-to-back: tx 0x11 then 0x22 written after tx_ready returns high; master sends 0xF0, 0x0F under one cs_n -> master receives 0x11, 0x22; rx_valid pulses twice with 0xF0, 0x0F.
REQ-046 Underrun: no tx write; 8-bit frame -> master receives 0x00; one tx_underrun pulse at frame start; tx_ready stays 1.
REQ-047 Abort: cs_n rises after 5 bits -> no rx_valid, rx_data unchanged, miso_oe=0; the next full frame receives correctly.
REQ-048 Reset mid-frame after 3 bits -> all outputs at reset values; after release, a new 0x5A frame is received as 0x5A.
REQ-049 Same-cycle write and reload (REQ-033) -> tx_underrun pulses; the written word appears on miso in the following word.
